// File: rtl/mem_host_port.sv
// Host word access scheduler for the G-15 recirculating lines: waits for the addressed
// word to reach the heads, then shifts 29 bits lsb first into or out of the selected line.
module mem_host_port #(
  parameter int WORD_BITS   = 29,
  parameter int LONG_WORDS  = 108,
  parameter int SHORT_WORDS = 4,
  parameter int MAX_REVS    = 2
) (
  input  logic                 CLOCK,
  input  logic                 rst_n,
  input  logic                 BIT_EN,
  input  logic                 TL,
  input  logic [6:0]           WORD_T,
  input  logic                 HOLD_OK,
  input  logic                 host_req,
  input  logic                 host_we,
  input  logic [4:0]           host_line,
  input  logic [6:0]           host_word,
  input  logic [WORD_BITS-1:0] host_wdata,
  output logic                 host_ack,
  output logic                 host_err,
  output logic [WORD_BITS-1:0] host_rdata,
  output logic                 busy,
  output logic [4:0]           line_sel,
  input  logic                 rd_bit,
  output logic                 wr_en,
  output logic                 wr_bit
);

  localparam int               REV_W     = $clog2(MAX_REVS + 1);
  localparam logic [6:0]       LAST_WORD = 7'(LONG_WORDS - 1);
  localparam logic [6:0]       LONG_LIM  = 7'(LONG_WORDS);
  localparam logic [6:0]       SHORT_LIM = 7'(SHORT_WORDS);
  localparam logic [4:0]       LAST_BIT  = 5'(WORD_BITS - 1);
  localparam logic [REV_W-1:0] REV_LIM   = REV_W'(MAX_REVS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_XFER = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t               state_r, state_nxt_s;
  logic                 we_r, we_nxt_s;
  logic                 err_r, err_nxt_s;
  logic [6:0]           word_r, word_nxt_s;
  logic [4:0]           line_nxt_s;
  logic [WORD_BITS-1:0] sh_r, sh_nxt_s;
  logic [4:0]           bit_cnt_r, bit_cnt_nxt_s;
  logic [REV_W-1:0]     rev_cnt_r, rev_cnt_nxt_s;

  logic                 req_long_s, req_short_s, addr_bad_s;
  logic                 sel_short_s, at_prev_s, start_s, rev_tick_s;
  logic [6:0]           prev_long_s;
  logic [1:0]           prev_short_s;
  logic [REV_W-1:0]     rev_inc_s;
  logic [WORD_BITS-1:0] shifted_s;

  // Lines 0-18 are long, 20-22 short; 19 and 23+ do not exist.
  assign req_long_s   = (host_line <= 5'd18);
  assign req_short_s  = (host_line >= 5'd20) && (host_line <= 5'd22);
  assign addr_bad_s   = !((req_long_s && (host_word < LONG_LIM)) ||
                          (req_short_s && (host_word < SHORT_LIM)));

  // Start on T28 of the word just before the target, so the first transfer bit is T0.
  assign sel_short_s  = (line_sel >= 5'd20);
  assign prev_long_s  = (word_r == 7'd0) ? LAST_WORD : (word_r - 7'd1);
  assign prev_short_s = word_r[1:0] - 2'd1;
  assign at_prev_s    = sel_short_s ? (WORD_T[1:0] == prev_short_s) : (WORD_T == prev_long_s);
  assign start_s      = BIT_EN & TL & HOLD_OK & at_prev_s;
  assign rev_tick_s   = BIT_EN & TL & (WORD_T == LAST_WORD);
  assign rev_inc_s    = rev_cnt_r + REV_W'(1);
  assign shifted_s    = {(we_r ? 1'b0 : rd_bit), sh_r[WORD_BITS-1:1]};

  // Next-state and datapath update for the access sequencer.
  always_comb begin
    state_nxt_s   = state_r;
    we_nxt_s      = we_r;
    err_nxt_s     = err_r;
    word_nxt_s    = word_r;
    line_nxt_s    = line_sel;
    sh_nxt_s      = sh_r;
    bit_cnt_nxt_s = bit_cnt_r;
    rev_cnt_nxt_s = rev_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (host_req) begin
          we_nxt_s      = host_we;
          line_nxt_s    = host_line;
          word_nxt_s    = host_word;
          sh_nxt_s      = host_wdata;
          bit_cnt_nxt_s = 5'd0;
          rev_cnt_nxt_s = '0;
          err_nxt_s     = addr_bad_s;
          state_nxt_s   = addr_bad_s ? ST_DONE : ST_WAIT;
        end else begin
          state_nxt_s   = ST_IDLE;
        end
      end
      ST_WAIT: begin
        // A start on the wrap strobe wins over the revolution timeout.
        if (start_s) begin
          bit_cnt_nxt_s = 5'd0;
          state_nxt_s   = ST_XFER;
        end else if (rev_tick_s) begin
          rev_cnt_nxt_s = rev_inc_s;
          if (rev_inc_s == REV_LIM) begin
            err_nxt_s   = 1'b1;
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_WAIT;
          end
        end else begin
          state_nxt_s   = ST_WAIT;
        end
      end
      ST_XFER: begin
        if (!HOLD_OK) begin
          err_nxt_s     = 1'b1;
          state_nxt_s   = ST_DONE;
        end else if (BIT_EN) begin
          sh_nxt_s      = shifted_s;
          bit_cnt_nxt_s = bit_cnt_r + 5'd1;
          state_nxt_s   = (bit_cnt_r == LAST_BIT) ? ST_DONE : ST_XFER;
        end else begin
          state_nxt_s   = ST_XFER;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Sequencer state and latched request.
  always_ff @(posedge CLOCK or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      we_r      <= 1'b0;
      err_r     <= 1'b0;
      word_r    <= 7'd0;
      line_sel  <= 5'd0;
      sh_r      <= '0;
      bit_cnt_r <= 5'd0;
      rev_cnt_r <= '0;
    end else begin
      state_r   <= state_nxt_s;
      we_r      <= we_nxt_s;
      err_r     <= err_nxt_s;
      word_r    <= word_nxt_s;
      line_sel  <= line_nxt_s;
      sh_r      <= sh_nxt_s;
      bit_cnt_r <= bit_cnt_nxt_s;
      rev_cnt_r <= rev_cnt_nxt_s;
    end
  end

  // Registered outputs, decoded from the next state so they line up with it.
  always_ff @(posedge CLOCK or negedge rst_n) begin
    if (!rst_n) begin
      host_ack   <= 1'b0;
      host_err   <= 1'b0;
      host_rdata <= '0;
      busy       <= 1'b0;
      wr_en      <= 1'b0;
      wr_bit     <= 1'b0;
    end else begin
      host_ack <= (state_nxt_s == ST_DONE);
      host_err <= (state_nxt_s == ST_DONE) && err_nxt_s;
      busy     <= (state_nxt_s == ST_WAIT) || (state_nxt_s == ST_XFER);
      wr_en    <= (state_nxt_s == ST_XFER) && we_nxt_s;
      wr_bit   <= ((state_nxt_s == ST_XFER) && we_nxt_s) ? sh_nxt_s[0] : 1'b0;
      if ((state_r == ST_XFER) && (state_nxt_s == ST_DONE) && !we_r && !err_nxt_s) begin
        host_rdata <= sh_nxt_s;
      end else begin
        host_rdata <= host_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_host_port.sv
// Bench for mem_host_port: drum timing and line memory model, request table with a
// scoreboard of expected completions, plus timeout, hold-drop and reset sequences.
module tb_mem_host_port;

  logic        CLOCK = 1'b0;
  logic        rst_n, BIT_EN, TL, HOLD_OK, host_req, host_we, rd_bit;
  logic [6:0]  WORD_T, host_word;
  logic [4:0]  host_line;
  logic [28:0] host_wdata;
  logic        host_ack, host_err, busy, wr_en, wr_bit;
  logic [28:0] host_rdata;
  logic [4:0]  line_sel;

  mem_host_port dut (
    .CLOCK(CLOCK), .rst_n(rst_n), .BIT_EN(BIT_EN), .TL(TL), .WORD_T(WORD_T),
    .HOLD_OK(HOLD_OK), .host_req(host_req), .host_we(host_we), .host_line(host_line),
    .host_word(host_word), .host_wdata(host_wdata), .host_ack(host_ack),
    .host_err(host_err), .host_rdata(host_rdata), .busy(busy), .line_sel(line_sel),
    .rd_bit(rd_bit), .wr_en(wr_en), .wr_bit(wr_bit)
  );

  always #5 CLOCK = ~CLOCK;

  // Drum model: one bit time every two clocks, short lines recirculate every 4 words.
  logic [28:0] mem [0:22][0:107];
  int  ph, bt, wt, bits, wr_cnt, wr_bad, inv_bad, pass_cnt, jump_done;
  time pass_time;
  bit  preloaded = 1'b0;
  int  jump_seq = 0, jump_wt = 0, exp_line = 0, exp_word = 0;

  function automatic int midx(input int line, input int w);
    return (line >= 20) ? (w % 4) : w;
  endfunction

  always @(negedge CLOCK) begin
    if (!preloaded) begin
      for (int l = 0; l < 23; l++)
        for (int w = 0; w < 108; w++) mem[l][w] = 29'h0;
      mem[20][0] = 29'h1000001; mem[20][1] = 29'h0AAAAAA;
      mem[20][2] = 29'h0000155; mem[20][3] = 29'h1FFFF00;
      mem[22][3] = 29'h1234567; mem[18][107] = 29'h0C0FFEE;
      ph = 0; bt = 0; wt = 0; bits = 0; wr_cnt = 0; wr_bad = 0; inv_bad = 0;
      pass_cnt = 0; jump_done = 0; pass_time = 0;
      BIT_EN = 1'b0; TL = 1'b0; WORD_T = 7'd0; rd_bit = 1'b0;
      preloaded = 1'b1;
    end else begin
      if (BIT_EN) begin
        bt++;
        if (bt == 29) begin
          bt = 0;
          wt = (wt == 107) ? 0 : wt + 1;
        end
      end
      if (jump_seq != jump_done) begin
        wt = jump_wt; bt = 0; ph = 1; jump_done = jump_seq;
      end
      ph     = (ph == 0) ? 1 : 0;
      BIT_EN = (ph == 1);
      TL     = (bt == 28);
      WORD_T = 7'(wt);
      rd_bit = 1'b0;
      if (BIT_EN) begin
        bits++;
        if (TL && wt == 107) begin
          pass_cnt++;
          pass_time = $time;
        end
        if (line_sel <= 5'd22) begin
          rd_bit = mem[int'(line_sel)][midx(int'(line_sel), wt)][bt];
          if (wr_en) begin
            mem[int'(line_sel)][midx(int'(line_sel), wt)][bt] = wr_bit;
            wr_cnt++;
            if (int'(line_sel) != exp_line || midx(int'(line_sel), wt) != exp_word) wr_bad++;
          end
        end else if (wr_en) begin
          wr_bad++;
        end
      end
      if (wr_en && !busy) inv_bad++;
    end
  end

  // Completion monitor: snapshot every ack.
  int          ack_cnt = 0, ack_bits = 0;
  logic        ack_err = 1'b0, ack_busy = 1'b0;
  logic [28:0] ack_rdata = 29'h0;
  time         ack_time = 0;

  always @(negedge CLOCK) begin
    if (host_ack) begin
      ack_cnt++;
      ack_err   = host_err;
      ack_rdata = host_rdata;
      ack_busy  = busy;
      ack_time  = $time;
      ack_bits  = bits;
    end
  end

  typedef struct {
    logic        we;
    logic [4:0]  line;
    logic [6:0]  word;
    logic [28:0] wdata;
    int          jump;
    logic        err;
    logic [28:0] rdata;
  } vec_t;

  typedef struct {
    string       name;
    logic        err;
    logic        chk_data;
    logic [28:0] data;
  } exp_t;

  exp_t sb_q[$];
  vec_t vt[13];
  int   errors = 0, checks = 0;
  int   lat_clk, lat_bits, wrs, wbad, w0h, a0r, w0r, p0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic jump_to(input int w);
    @(posedge CLOCK);
    jump_wt = w;
    jump_seq++;
    repeat (2) @(negedge CLOCK);
  endtask

  task automatic run_req(input string name, input logic we, input logic [4:0] line,
                         input logic [6:0] word, input logic [28:0] wdata,
                         input logic exp_err, input logic [28:0] exp_rdata,
                         output int o_lat_clk, output int o_lat_bits,
                         output int o_wrs, output int o_wbad);
    exp_t e, got;
    int   a0, w0, b0, bits0;
    time  t0;
    e.name = name; e.err = exp_err; e.chk_data = !we && !exp_err; e.data = exp_rdata;
    @(negedge CLOCK);
    exp_line = int'(line);
    exp_word = midx(int'(line), int'(word));
    a0 = ack_cnt; w0 = wr_cnt; b0 = wr_bad; bits0 = bits; t0 = $time;
    host_req = 1'b1; host_we = we; host_line = line; host_word = word; host_wdata = wdata;
    sb_q.push_back(e);
    @(negedge CLOCK);
    host_req = 1'b0;
    for (int i = 0; i < 25000 && ack_cnt == a0; i++) @(negedge CLOCK);
    o_lat_clk = 0; o_lat_bits = 0;
    if (ack_cnt == a0) begin
      chk({name, "_ack_timeout"}, 32'd0, 32'd1);
      void'(sb_q.pop_back());
    end else begin
      got = sb_q.pop_front();
      chk({got.name, "_err"}, {31'd0, ack_err}, {31'd0, got.err});
      if (got.chk_data) chk({got.name, "_rdata"}, {3'd0, ack_rdata}, {3'd0, got.data});
      chk({got.name, "_busy_at_ack"}, {31'd0, ack_busy}, 32'd0);
      o_lat_clk  = int'((ack_time - t0) / 10);
      o_lat_bits = ack_bits - bits0;
    end
    repeat (3) @(negedge CLOCK);
    chk({name, "_one_ack"}, ack_cnt - a0, 32'd1);
    o_wrs  = wr_cnt - w0;
    o_wbad = wr_bad - b0;
  endtask

  initial begin
    rst_n = 1'b0; HOLD_OK = 1'b1; host_req = 1'b0; host_we = 1'b0;
    host_line = 5'd0; host_word = 7'd0; host_wdata = 29'h0;
    vt[0]  = '{1'b1, 5'd3,  7'd0,   29'h1ABCDEF, 50,  1'b0, 29'h0};
    vt[1]  = '{1'b0, 5'd3,  7'd0,   29'h0,       20,  1'b0, 29'h1ABCDEF};
    vt[2]  = '{1'b0, 5'd20, 7'd2,   29'h0,       10,  1'b0, 29'h0000155};
    vt[3]  = '{1'b1, 5'd21, 7'd1,   29'h0A5A5A5, 7,   1'b0, 29'h0};
    vt[4]  = '{1'b0, 5'd21, 7'd1,   29'h0,       60,  1'b0, 29'h0A5A5A5};
    vt[5]  = '{1'b0, 5'd22, 7'd3,   29'h0,       0,   1'b0, 29'h1234567};
    vt[6]  = '{1'b0, 5'd18, 7'd107, 29'h0,       100, 1'b0, 29'h0C0FFEE};
    vt[7]  = '{1'b1, 5'd19, 7'd0,   29'h1FFFFFFF, -1, 1'b1, 29'h0};
    vt[8]  = '{1'b0, 5'd23, 7'd0,   29'h0,       -1,  1'b1, 29'h0};
    vt[9]  = '{1'b1, 5'd21, 7'd5,   29'h1FFFFFFF, -1, 1'b1, 29'h0};
    vt[10] = '{1'b0, 5'd0,  7'd108, 29'h0,       -1,  1'b1, 29'h0};
    vt[11] = '{1'b1, 5'd31, 7'd3,   29'h1FFFFFFF, -1, 1'b1, 29'h0};
    vt[12] = '{1'b0, 5'd20, 7'd4,   29'h0,       -1,  1'b1, 29'h0};

    repeat (4) @(negedge CLOCK);
    chk("rst_ack",   {31'd0, host_ack}, 32'd0);
    chk("rst_err",   {31'd0, host_err}, 32'd0);
    chk("rst_busy",  {31'd0, busy},     32'd0);
    chk("rst_wr_en", {31'd0, wr_en},    32'd0);
    chk("rst_wr_bit",{31'd0, wr_bit},   32'd0);
    chk("rst_rdata", {3'd0, host_rdata}, 32'd0);
    chk("rst_line",  {27'd0, line_sel}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      if (vt[i].jump >= 0) jump_to(vt[i].jump);
      run_req($sformatf("v%0d", i), vt[i].we, vt[i].line, vt[i].word, vt[i].wdata,
              vt[i].err, vt[i].rdata, lat_clk, lat_bits, wrs, wbad);
      chk($sformatf("v%0d_wr_pulses", i), wrs, (vt[i].we && !vt[i].err) ? 32'd29 : 32'd0);
      chk($sformatf("v%0d_wr_place", i), wbad, 32'd0);
      if (vt[i].err) chk($sformatf("v%0d_bad_latency", i), lat_clk, 32'd1);
      else chk($sformatf("v%0d_latency_bound", i),
               {31'd0, (lat_bits >= 29) && (lat_bits <= ((vt[i].line >= 5'd20) ? 145 : 3161))},
               32'd1);
    end
    chk("w0_mem_word0",   {3'd0, mem[3][0]},   32'h1ABCDEF);
    chk("w0_mem_word1",   {3'd0, mem[3][1]},   32'd0);
    chk("w0_mem_word107", {3'd0, mem[3][107]}, 32'd0);

    // Timeout: HOLD_OK low for the whole wait.
    jump_to(50);
    HOLD_OK = 1'b0;
    p0 = pass_cnt;
    run_req("timeout", 1'b0, 5'd5, 7'd10, 29'h0, 1'b1, 29'h0, lat_clk, lat_bits, wrs, wbad);
    chk("timeout_passes", pass_cnt - p0, 32'd2);
    chk("timeout_ack_after_pass", int'(ack_time - pass_time), 32'd10);
    chk("timeout_wr_pulses", wrs, 32'd0);
    HOLD_OK = 1'b1;

    // HOLD_OK drops right after bit 10 of a write.
    jump_to(0);
    w0h = wr_cnt;
    fork
      run_req("hold_drop", 1'b1, 5'd4, 7'd5, 29'h1FFFFFFF, 1'b1, 29'h0, lat_clk, lat_bits, wrs, wbad);
      begin
        for (int i = 0; i < 25000; i++) begin
          @(posedge CLOCK);
          if (wr_cnt - w0h >= 11) break;
        end
        @(negedge CLOCK);
        HOLD_OK = 1'b0;
      end
    join
    HOLD_OK = 1'b1;
    chk("hold_drop_wr_pulses", wrs, 32'd11);
    chk("hold_drop_mem", {3'd0, mem[4][5]}, 32'h7FF);
    chk("hold_drop_wr_place", wbad, 32'd0);

    // Reset pulsed during a write transfer.
    jump_to(0);
    @(negedge CLOCK);
    exp_line = 6; exp_word = 2;
    a0r = ack_cnt; w0r = wr_cnt;
    host_req = 1'b1; host_we = 1'b1; host_line = 5'd6; host_word = 7'd2; host_wdata = 29'h0123456;
    @(negedge CLOCK);
    host_req = 1'b0;
    for (int i = 0; i < 25000; i++) begin
      @(posedge CLOCK);
      if (wr_cnt - w0r >= 5) break;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_wr_en", {31'd0, wr_en},    32'd0);
    chk("rst_mid_busy",  {31'd0, busy},     32'd0);
    chk("rst_mid_ack",   {31'd0, host_ack}, 32'd0);
    @(negedge CLOCK);
    rst_n = 1'b1;
    chk("rst_mid_no_ack", ack_cnt - a0r, 32'd0);
    run_req("after_rst", 1'b0, 5'd3, 7'd0, 29'h0, 1'b0, 29'h1ABCDEF, lat_clk, lat_bits, wrs, wbad);
    chk("after_rst_wr_pulses", wrs, 32'd0);

    chk("wr_en_only_busy", inv_bad, 32'd0);
    chk("scoreboard_empty", sb_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
